// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared types for the data-memory request/response interface.
//   memReqStruct  : initiator -> responder (addr, wr_data, MemWrite, MemRead, valid)
//   memRespStruct : responder -> initiator (rd_data, MemWrite, MemRead, valid)
//   memRespState_e: responder FSM states
//   MEM_LATENCY   : default accept-to-response latency in cycles
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int MEM_LATENCY = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        MemWrite;
    logic        MemRead;
    logic        valid;
  } memReqStruct;

  typedef struct packed {
    logic [31:0] rd_data;
    logic        MemWrite;
    logic        MemRead;
    logic        valid;
  } memRespStruct;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memRespState_e;

endpackage

// File: rtl/data_mem_responder_ram.sv
// ----------------------------------------------------------------------------
// dmem_ram
//   DEPTH x 32 single-port synchronous RAM, no reset, registered read.
//   A write cycle does not update the read register (the responder returns
//   zero for writes), so the read path always reflects pre-write contents.
//   Ports:
//     clk      in   clock
//     en_i     in   perform an access this edge
//     we_i     in   1 = write wdata_i, 0 = read into rdata_o
//     idx_i    in   word index
//     wdata_i  in   write data
//     rdata_o  out  registered read data
// ----------------------------------------------------------------------------
module dmem_ram #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] idx_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Responder for one-outstanding word requests. A request accepted on
//   req.valid && req_ready is serviced from an internal RAM; a single-cycle
//   response pulse follows LATENCY cycles after the accept edge. flush
//   cancels a request still waiting for its access.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous reset, active low
//     req        in   memReqStruct request
//     req_ready  out  request can be accepted this cycle
//     flush      in   drop the pending (not yet performed) request
//     resp       out  memRespStruct response (all zero outside RESP)
// ----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int LATENCY   = MEM_LATENCY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  memReqStruct  req,
  output logic         req_ready,
  input  logic         flush,
  output memRespStruct resp
);

  memRespState_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  // Latched request for the LATENCY>1 path
  logic [ADDR_BITS-1:0] lat_idx_q;
  logic [31:0]          lat_wdata_q;
  logic                 lat_we_q;
  logic                 lat_re_q;

  // Flags of the access performed on entry to RESP
  logic resp_we_q;
  logic resp_re_q;

  logic                 accept;
  logic                 latch_req;
  logic                 access;
  logic                 use_live;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [31:0]          acc_wdata;
  logic                 acc_we;
  logic                 acc_re;
  logic [31:0]          ram_rdata;
  logic                 unused_addr_bits;

  // Only the word-index bits of addr matter; the rest are intentionally ignored.
  assign unused_addr_bits = ^req.addr;

  // Held low during reset so nothing is accepted while rst_n is asserted.
  assign req_ready = rst_n && ((state_q == IDLE) || (state_q == RESP)) && !flush;
  assign accept    = req.valid && req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_req = 1'b0;
    access    = 1'b0;
    use_live  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        // RESP lasts one cycle; a new accept here gives back-to-back service.
        state_d = IDLE;
        if (accept) begin
          if (LATENCY == 1) begin
            state_d  = RESP;
            access   = 1'b1;
            use_live = 1'b1;
          end else begin
            state_d   = WAIT;
            cnt_d     = 4'(LATENCY - 1);
            latch_req = 1'b1;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          // Flush wins over a due access: nothing is performed.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign acc_idx   = use_live ? req.addr[ADDR_BITS+1:2] : lat_idx_q;
  assign acc_wdata = use_live ? req.wr_data             : lat_wdata_q;
  assign acc_we    = use_live ? req.MemWrite            : lat_we_q;
  assign acc_re    = use_live ? req.MemRead             : lat_re_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      lat_idx_q   <= '0;
      lat_wdata_q <= '0;
      lat_we_q    <= 1'b0;
      lat_re_q    <= 1'b0;
      resp_we_q   <= 1'b0;
      resp_re_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        lat_idx_q   <= req.addr[ADDR_BITS+1:2];
        lat_wdata_q <= req.wr_data;
        lat_we_q    <= req.MemWrite;
        lat_re_q    <= req.MemRead;
      end
      if (access) begin
        resp_we_q <= acc_we;
        resp_re_q <= acc_re;
      end
    end
  end

  dmem_ram #(
    .DEPTH    (DEPTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk    (clk),
    .en_i   (access),
    .we_i   (acc_we),
    .idx_i  (acc_idx),
    .wdata_i(acc_wdata),
    .rdata_o(ram_rdata)
  );

  // Read data is only meaningful for a pure read; writes and no-ops return 0.
  always_comb begin
    resp = '0;
    if (state_q == RESP) begin
      resp.valid    = 1'b1;
      resp.MemWrite = resp_we_q;
      resp.MemRead  = resp_re_q;
      resp.rd_data  = (resp_re_q && !resp_we_q) ? ram_rdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench: dut uses LATENCY=2, dut1 uses LATENCY=1.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic         clk;
  logic         rst_n;
  memReqStruct  req0, req1;
  logic         rdy0, rdy1;
  logic         flush0, flush1;
  memRespStruct resp0, resp1;

  int tests_run = 0;
  int tests_failed = 0;

  data_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_ready(rdy0),
    .flush(flush0), .resp(resp0)
  );

  data_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_ready(rdy1),
    .flush(flush1), .resp(resp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic w, input logic r, input logic v);
    memReqStruct rq;
    rq.addr = addr; rq.wr_data = wdata; rq.MemWrite = w; rq.MemRead = r; rq.valid = v;
    if (sel) req1 = rq; else req0 = rq;
  endtask

  // One transaction: drive, wait for accept, measure latency in cycles after
  // the accept edge until resp.valid is seen.
  task automatic txn(input bit sel, input string tag, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic w, input logic r,
                     output memRespStruct rsp, output int lat);
    int waited;
    waited = 0;
    lat = 0;
    rsp = '0;
    @(negedge clk);
    set_req(sel, addr, wdata, w, r, 1'b1);
    while (!(sel ? rdy1 : rdy0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_ready_to"}, 32'(waited < 20), 32'd1);
    @(posedge clk);
    #1;
    if (sel) req1.valid = 1'b0; else req0.valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((sel ? resp1.valid : resp0.valid) === 1'b1) begin
        lat = i;
        rsp = sel ? resp1 : resp0;
        break;
      end
    end
    check_eq({tag, "_resp_seen"}, 32'(lat != 0), 32'd1);
    $display("[TB] txn %s dut%0d addr=0x%08h w=%0b r=%0b lat=%0d rd=0x%08h",
             tag, sel, addr, w, r, lat, rsp.rd_data);
  endtask

  // Watch n cycles and return how many had resp.valid set
  task automatic count_resp(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (resp0.valid === 1'b1) seen++;
    end
  endtask

  memRespStruct r;
  int lat;
  int seen;

  initial begin
    rst_n  = 1'b0;
    flush0 = 1'b0;
    flush1 = 1'b0;
    req0   = '0;
    req1   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_resp", 32'(resp0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(rdy0), 32'd1);
    check_eq("rst_resp_after", 32'(resp0), 32'd0);

    // 1: write then read, LATENCY=2
    txn(0, "wr10", 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, r, lat);
    check_eq("wr10_lat", 32'(lat), 32'd2);
    check_eq("wr10_rd", r.rd_data, 32'd0);
    check_eq("wr10_mw", 32'(r.MemWrite), 32'd1);
    txn(0, "rd10", 32'h10, 32'h0, 1'b0, 1'b1, r, lat);
    check_eq("rd10_lat", 32'(lat), 32'd2);
    check_eq("rd10_rd", r.rd_data, 32'hDEADBEEF);
    check_eq("rd10_mr", 32'(r.MemRead), 32'd1);
    check_eq("rd10_mw", 32'(r.MemWrite), 32'd0);

    // 2: back-to-back; second request held during the first's RESP cycle
    @(negedge clk);
    set_req(0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    set_req(0, 32'h14, 32'h0BADF00D, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("b2b_wait_ready", 32'(rdy0), 32'd0);
    @(negedge clk);
    check_eq("b2b_first_valid", 32'(resp0.valid), 32'd1);
    check_eq("b2b_first_rd", resp0.rd_data, 32'hDEADBEEF);
    check_eq("b2b_resp_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    #1;
    req0.valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_gap_valid", 32'(resp0.valid), 32'd0);
    @(negedge clk);
    check_eq("b2b_second_valid", 32'(resp0.valid), 32'd1);
    check_eq("b2b_second_mw", 32'(resp0.MemWrite), 32'd1);
    $display("[TB] txn b2b second resp valid=%0b", resp0.valid);
    txn(0, "rd14", 32'h14, 32'h0, 1'b0, 1'b1, r, lat);
    check_eq("rd14_rd", r.rd_data, 32'h0BADF00D);

    // 3: flush a read in WAIT
    txn(0, "wr20", 32'h20, 32'h1234, 1'b1, 1'b0, r, lat);
    @(negedge clk);
    set_req(0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    req0.valid = 1'b0;
    flush0 = 1'b1;
    @(negedge clk);
    check_eq("fl_rd_wait_ready", 32'(rdy0), 32'd0);
    @(posedge clk);
    #1;
    flush0 = 1'b0;
    @(negedge clk);
    check_eq("fl_rd_ready", 32'(rdy0), 32'd1);
    check_eq("fl_rd_valid", 32'(resp0.valid), 32'd0);
    count_resp(4, seen);
    check_eq("fl_rd_noresp", 32'(seen), 32'd0);
    $display("[TB] txn flush read 0x20 responses=%0d", seen);
    txn(0, "rd20", 32'h20, 32'h0, 1'b0, 1'b1, r, lat);
    check_eq("rd20_rd", r.rd_data, 32'h1234);

    // 4: flushed write leaves old contents
    txn(0, "wr0_pre", 32'h0, 32'h0, 1'b1, 1'b0, r, lat);
    @(negedge clk);
    set_req(0, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    req0.valid = 1'b0;
    flush0 = 1'b1;
    @(posedge clk);
    #1;
    flush0 = 1'b0;
    count_resp(3, seen);
    check_eq("fl_wr_noresp", 32'(seen), 32'd0);
    $display("[TB] txn flush write 0x0 responses=%0d", seen);
    txn(0, "rd0_old", 32'h0, 32'h0, 1'b0, 1'b1, r, lat);
    check_eq("rd0_old_rd", r.rd_data, 32'h0);

    // 5: address wrap and ignored low bits
    txn(0, "wr1000", 32'h1000, 32'h55, 1'b1, 1'b0, r, lat);
    txn(0, "rd0_wrap", 32'h0, 32'h0, 1'b0, 1'b1, r, lat);
    check_eq("wrap_rd", r.rd_data, 32'h55);
    txn(0, "rd3", 32'h3, 32'h0, 1'b0, 1'b1, r, lat);
    check_eq("lowbits_rd", r.rd_data, 32'h55);

    // Both flags set: write wins, rd_data=0, flags echoed
    txn(0, "wr40_both", 32'h40, 32'h77, 1'b1, 1'b1, r, lat);
    check_eq("both_rd", r.rd_data, 32'd0);
    check_eq("both_mw", 32'(r.MemWrite), 32'd1);
    check_eq("both_mr", 32'(r.MemRead), 32'd1);
    txn(0, "rd40", 32'h40, 32'h0, 1'b0, 1'b1, r, lat);
    check_eq("rd40_rd", r.rd_data, 32'h77);

    // No-op request still gets a response with rd_data=0
    txn(0, "noop", 32'h40, 32'hFFFF, 1'b0, 1'b0, r, lat);
    check_eq("noop_lat", 32'(lat), 32'd2);
    check_eq("noop_rd", r.rd_data, 32'd0);

    // LATENCY=1 instance
    txn(1, "l1_wr8", 32'h8, 32'hCAFEF00D, 1'b1, 1'b0, r, lat);
    check_eq("l1_wr_lat", 32'(lat), 32'd1);
    txn(1, "l1_rd8", 32'h8, 32'h0, 1'b0, 1'b1, r, lat);
    check_eq("l1_rd_lat", 32'(lat), 32'd1);
    check_eq("l1_rd_rd", r.rd_data, 32'hCAFEF00D);

    // 6: async reset mid-WAIT drops a pending write
    txn(0, "wr80", 32'h80, 32'h11111111, 1'b1, 1'b0, r, lat);
    @(negedge clk);
    set_req(0, 32'h80, 32'h22222222, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    req0.valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_resp", 32'(resp0), 32'd0);
    check_eq("arst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("arst_ready", 32'(rdy0), 32'd1);
    count_resp(4, seen);
    check_eq("arst_noresp", 32'(seen), 32'd0);
    $display("[TB] txn async reset during WAIT responses=%0d", seen);
    txn(0, "rd80", 32'h80, 32'h0, 1'b0, 1'b1, r, lat);
    check_eq("rd80_rd", r.rd_data, 32'h11111111);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
